mips_bus_responder: RTL and testbench
=====================================

# mips_bus_responder

Memory-mapped responder on the far side of the MIPS core's external 8-bit address/data bus. It accepts four-phase request/acknowledge transactions from the core and serves them from a small scratch RAM and a handful of peripheral registers: GPIO out, synchronised GPIO in, timer, timer compare and status. It inserts a programmable number of wait states and flags unmapped accesses. It sits beside the core inside the SoC and gives the core a complete bus target.

## Interface
- `MEM_WORDS`, 16: scratch RAM depth in bytes; power of two, 2..128; mapped at 0x00..MEM_WORDS-1.
- `WAIT_STATES`, 2: extra cycles inserted before every acknowledge; 0..15.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `bus_req` in 1: transaction request from the core; held high until `bus_ack` is seen.
- `bus_we` in 1: 1 = write, 0 = read; sampled with `bus_req`.
- `bus_addr` in 8: byte address.
- `bus_wdata` in 8: write data.
- `bus_rdata` out 8: read data; valid while `bus_ack` = 1.
- `bus_ack` out 1: transaction complete.
- `bus_err` out 1: unmapped address; valid while `bus_ack` = 1.
- `gpio_in` in 8: asynchronous external inputs.
- `gpio_out` out 8: GPIO output register.
- `timer_irq` out 1: sticky timer-match flag.

## Operation
- Address map:
  - 0x00..MEM_WORDS-1: RAM, read/write.
  - 0xF0: GPIO_OUT, read/write.
  - 0xF1: GPIO_IN, read-only.
  - 0xF2: TIMER; a write clears it to 0.
  - 0xF3: TIMER_CMP, read/write.
  - 0xF4: STATUS; bit0 = irq; writing 1 to bit0 clears it; other bits read 0.
  - Any other address: `bus_err` = 1, `bus_rdata` = 0x00, writes have no effect.
  - Writes to GPIO_IN are accepted and ignored, with no error.
- States:
  - IDLE: when `bus_req` = 1, latch addr/wdata/we and load the wait counter with `WAIT_STATES`. Go to ACCESS if `WAIT_STATES` = 0, otherwise to WAIT.
  - WAIT: decrement the counter; on reaching 0, go to ACCESS.
  - ACCESS: perform the read or write; register `bus_rdata`/`bus_err`; set `bus_ack` = 1; go to HOLD.
  - HOLD: hold `bus_ack`, `bus_rdata` and `bus_err` stable while `bus_req` = 1. When `bus_req` = 0, clear `bus_ack` and go to IDLE.
- Bus inputs that change after the latch edge are ignored.
- If `bus_req` drops before ack, the transaction still completes, `bus_ack` pulses for exactly one cycle, then the FSM returns to IDLE.
- `gpio_in` passes through a 2-flop synchroniser; GPIO_IN reads the second stage.
- TIMER is an 8-bit counter:
  - Increments every cycle and wraps 0xFF→0x00.
  - A write to TIMER loads 0, and the write wins over that cycle's increment.
- IRQ flag:
  - Set when TIMER equals TIMER_CMP and TIMER_CMP ≠ 0. It stays set until cleared through STATUS.
  - If set and clear occur in the same cycle, set wins.
  - `timer_irq` drives this flag directly.
- RAM is not reset; its contents after reset are undefined.

## Timing
- Reset values: `bus_rdata` = 0x00, `bus_ack` = 0, `bus_err` = 0, `gpio_out` = 0x00, `timer_irq` = 0. FSM = IDLE, TIMER = 0, TIMER_CMP = 0, synchroniser = 0.
- Reset mid-transaction: the FSM returns to IDLE immediately, `bus_ack` deasserts asynchronously, and a pending write is discarded.
- Latency: `bus_req` is sampled high at edge E0. `bus_ack` rises at edge E0+WAIT_STATES+1.
- Write effects and read data register on the same edge as `bus_ack` rises.
- Read values:
  - Read data reflects register state before that edge.
  - A TIMER read returns the value before that edge's increment.
- `bus_ack` falls on the first edge at which `bus_req` = 0 is sampled in HOLD.
- The next request is accepted no earlier than the edge after that.
- Minimum transaction: WAIT_STATES+3 cycles, req-sampled to the next accept.
- GPIO_IN latency: 2 edges from `gpio_in` to readable.
- IRQ timing: the flag sets on the edge after TIMER == TIMER_CMP, one edge after the matching count appears.

## Test plan
- WAIT_STATES = 2: write 0x5A to 0x03, then read 0x03.
  - Ack rises 3 edges after req is sampled.
  - Read returns 0x5A with `bus_err` = 0.
- Write 0xC3 to 0xF0.
  - `gpio_out` = 0xC3 on the ack edge.
  - A subsequent read of 0xF0 returns 0xC3.
- Read 0x80 and write to 0xFF.
  - Both transactions ack with `bus_err` = 1.
  - The read returns 0x00.
  - No RAM or register changes.
- Write 0x10 to TIMER_CMP, then write to TIMER.
  - `timer_irq` rises 17 edges after the TIMER clear edge.
  - Writing 0x01 to STATUS clears it.
  - A clear issued on the match edge leaves the flag set.
- Drive `gpio_in` = 0xA5.
  - A read of 0xF1 issued ≥2 cycles later returns 0xA5.
- Assert `rst_n` low during WAIT of a write to 0x01.
  - `bus_ack` = 0 immediately and RAM[0x01] is unchanged.
  - Drop req before ack in a second transaction: `bus_ack` is high for exactly 1 cycle.

Source files
------------

// File: rtl/mips_bus_responder.sv
// -----------------------------------------------------------------------------
// mips_bus_responder
//
// Bus target for the MIPS core's external 8-bit address/data bus. It serves
// four-phase req/ack transactions from a small scratch RAM and a few peripheral
// registers, and inserts a fixed number of wait states before every ack.
//
// Address map:
//   0x00..MEM_WORDS-1  scratch RAM (r/w, not reset)
//   0xF0               GPIO_OUT  (r/w)
//   0xF1               GPIO_IN   (read-only, synchronised; writes ignored)
//   0xF2               TIMER     (free-running, a write clears it)
//   0xF3               TIMER_CMP (r/w)
//   0xF4               STATUS    (bit0 = irq, write 1 to clear)
//   anything else      bus_err = 1, rdata = 0x00, writes dropped
//
// Handshake: the core raises bus_req with bus_we/bus_addr/bus_wdata valid and
// holds it until it sees bus_ack. The request is latched on the first edge
// that samples bus_req high in IDLE; later changes on the bus inputs are
// ignored. bus_ack rises WAIT_STATES+1 edges after that, with bus_rdata and
// bus_err valid, and stays high until an edge samples bus_req low. A req that
// drops early still completes and gives a single-cycle ack pulse.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus_req, bus_we   request and direction (1 = write)
//   bus_addr          byte address
//   bus_wdata         write data
//   bus_rdata         read data, valid while bus_ack = 1
//   bus_ack           transaction complete
//   bus_err           unmapped address, valid while bus_ack = 1
//   gpio_in           asynchronous external inputs
//   gpio_out          GPIO output register
//   timer_irq         sticky timer-match flag
//   dbg_state         current FSM state (0 IDLE, 1 WAIT, 2 ACCESS, 3 HOLD)
// -----------------------------------------------------------------------------
module mips_bus_responder #(
    parameter int MEM_WORDS   = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_req,
    input  logic       bus_we,
    input  logic [7:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_ack,
    output logic       bus_err,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic       timer_irq,
    output logic [1:0] dbg_state
);

    localparam int         AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [7:0] RAM_TOP = 8'(MEM_WORDS - 1);
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    localparam logic [7:0] A_GPIO_OUT  = 8'hF0;
    localparam logic [7:0] A_GPIO_IN   = 8'hF1;
    localparam logic [7:0] A_TIMER     = 8'hF2;
    localparam logic [7:0] A_TIMER_CMP = 8'hF3;
    localparam logic [7:0] A_STATUS    = 8'hF4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] wait_cnt;
    logic       lat_we;
    logic [7:0] lat_addr;
    logic [7:0] lat_wdata;

    logic [7:0] mem [MEM_WORDS];

    logic [7:0] timer;
    logic [7:0] timer_cmp;
    logic       irq;
    logic [7:0] gpio_sync1;
    logic [7:0] gpio_sync2;

    // Address decode works on the latched address so late bus changes can't
    // disturb a transaction in flight.
    logic       is_ram, is_gpo, is_gpi, is_tmr, is_cmp, is_sts, mapped;
    logic [7:0] rd_val;
    logic       acc_wr;
    logic       irq_set, irq_clr;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus_req) begin
                    state_nxt = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                // The counter reaches 0 on this edge when it currently holds 1.
                if (wait_cnt <= 4'd1) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!bus_req) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign dbg_state = state;

    // Ack is a decode of the registered state, so an asynchronous reset drops
    // it immediately along with the FSM.
    assign bus_ack = (state == S_HOLD);

    // -------------------------------------------------------------------------
    // Request latch and wait counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 8'h00;
            lat_wdata <= 8'h00;
        end else begin
            if (state == S_IDLE && bus_req) begin
                wait_cnt  <= WS_LOAD;
                lat_we    <= bus_we;
                lat_addr  <= bus_addr;
                lat_wdata <= bus_wdata;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Decode and read mux
    // -------------------------------------------------------------------------
    always_comb begin
        is_ram = (lat_addr <= RAM_TOP);
        is_gpo = (lat_addr == A_GPIO_OUT);
        is_gpi = (lat_addr == A_GPIO_IN);
        is_tmr = (lat_addr == A_TIMER);
        is_cmp = (lat_addr == A_TIMER_CMP);
        is_sts = (lat_addr == A_STATUS);
        mapped = is_ram | is_gpo | is_gpi | is_tmr | is_cmp | is_sts;
    end

    // Reads see the state before the access edge, including the pre-increment
    // timer value.
    always_comb begin
        rd_val = 8'h00;
        if (is_ram) begin
            rd_val = mem[lat_addr[AW-1:0]];
        end else if (is_gpo) begin
            rd_val = gpio_out;
        end else if (is_gpi) begin
            rd_val = gpio_sync2;
        end else if (is_tmr) begin
            rd_val = timer;
        end else if (is_cmp) begin
            rd_val = timer_cmp;
        end else if (is_sts) begin
            rd_val = {7'd0, irq};
        end
    end

    assign acc_wr = (state == S_ACCESS) && lat_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_rdata <= 8'h00;
            bus_err   <= 1'b0;
        end else if (state == S_ACCESS) begin
            bus_rdata <= rd_val;
            bus_err   <= ~mapped;
        end
    end

    // -------------------------------------------------------------------------
    // Scratch RAM (no reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (acc_wr && is_ram) begin
            mem[lat_addr[AW-1:0]] <= lat_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Peripheral registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out  <= 8'h00;
            timer_cmp <= 8'h00;
        end else if (acc_wr) begin
            if (is_gpo) begin
                gpio_out <= lat_wdata;
            end
            if (is_cmp) begin
                timer_cmp <= lat_wdata;
            end
        end
    end

    // Clearing write takes priority over the free-running increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= 8'h00;
        end else if (acc_wr && is_tmr) begin
            timer <= 8'h00;
        end else begin
            timer <= timer + 8'd1;
        end
    end

    // A compare value of zero disables matching. Set wins over a same-cycle
    // clear so a match is never lost.
    assign irq_set = (timer == timer_cmp) && (timer_cmp != 8'h00);
    assign irq_clr = acc_wr && is_sts && lat_wdata[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_set | (irq & ~irq_clr);
        end
    end

    assign timer_irq = irq;

    // Two-flop synchroniser for the asynchronous GPIO inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_sync1 <= 8'h00;
            gpio_sync2 <= 8'h00;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
        end
    end

endmodule

// File: tb/tb_mips_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_mips_bus_responder
//
// Directed bench for mips_bus_responder with WAIT_STATES = 2 and MEM_WORDS = 16.
// A table of single transactions covers the address map; hand-written
// sequences cover timer/irq timing, GPIO input synchronisation, reset during
// a transaction and an early-dropped request. Edges are numbered by cyc, which
// increments on every rising edge; outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_mips_bus_responder;

    localparam int WS = 2;
    localparam int MW = 16;

    logic       clk;
    logic       rst_n;
    logic       bus_req;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic       bus_err;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic       timer_irq;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];

    mips_bus_responder #(
        .MEM_WORDS   (MW),
        .WAIT_STATES (WS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge with the bus idle. Raises req, scrambles the bus
    // inputs once the request has been latched, waits for ack, then drops req
    // and confirms ack falls on the next edge.
    task automatic bus_xfer(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                            output logic [7:0] rd, output logic er, output int ack_edge);
        int start;
        start     = cyc;
        ack_edge  = -1;
        rd        = 8'h00;
        er        = 1'b0;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        bus_req   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus_we    = ~we;
                bus_addr  = ~addr;
                bus_wdata = ~wdata;
            end
            if (bus_ack) begin
                ack_edge = cyc;
                break;
            end
        end
        if (ack_edge < 0) begin
            check("ack_timeout", 0, 1);
            bus_req = 1'b0;
            @(negedge clk);
        end else begin
            rd = bus_rdata;
            er = bus_err;
            check("ack_latency", ack_edge - start, WS + 2);
            bus_req = 1'b0;
            @(negedge clk);
            check("ack_fall", int'(bus_ack), 0);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       chk_rd;
        logic [7:0] exp_rd;
        logic       exp_err;
        logic [7:0] exp_gpio;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    initial begin
        logic [7:0] rd;
        logic       er;
        int         ae;
        int         c_clr;
        int         irq_edge;
        int         ack_cnt;
        int         s;
        logic [7:0] exp;

        //               we    addr   wdata  chk   exp_rd exp_err gpio
        vecs[0]  = '{1'b1, 8'h03, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h03, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 8'hF0, 8'hC3, 1'b0, 8'h00, 1'b0, 8'hC3};
        vecs[3]  = '{1'b0, 8'hF0, 8'h00, 1'b1, 8'hC3, 1'b0, 8'hC3};
        vecs[4]  = '{1'b0, 8'h80, 8'h00, 1'b1, 8'h00, 1'b1, 8'hC3};
        vecs[5]  = '{1'b1, 8'hFF, 8'h77, 1'b0, 8'h00, 1'b1, 8'hC3};
        vecs[6]  = '{1'b0, 8'h03, 8'h00, 1'b1, 8'h5A, 1'b0, 8'hC3};
        vecs[7]  = '{1'b0, 8'hF0, 8'h00, 1'b1, 8'hC3, 1'b0, 8'hC3};
        vecs[8]  = '{1'b1, 8'h00, 8'h11, 1'b0, 8'h00, 1'b0, 8'hC3};
        vecs[9]  = '{1'b1, 8'h0F, 8'hEE, 1'b0, 8'h00, 1'b0, 8'hC3};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b0, 8'hC3};
        vecs[11] = '{1'b0, 8'h0F, 8'h00, 1'b1, 8'hEE, 1'b0, 8'hC3};
        vecs[12] = '{1'b0, 8'h10, 8'h00, 1'b1, 8'h00, 1'b1, 8'hC3};
        vecs[13] = '{1'b1, 8'hF1, 8'h99, 1'b0, 8'h00, 1'b0, 8'hC3};
        vecs[14] = '{1'b0, 8'hF1, 8'h00, 1'b1, 8'h00, 1'b0, 8'hC3};
        vecs[15] = '{1'b1, 8'hF3, 8'h10, 1'b0, 8'h00, 1'b0, 8'hC3};
        vecs[16] = '{1'b0, 8'hF3, 8'h00, 1'b1, 8'h10, 1'b0, 8'hC3};
        vecs[17] = '{1'b0, 8'hF5, 8'h00, 1'b1, 8'h00, 1'b1, 8'hC3};
        vecs[18] = '{1'b1, 8'h10, 8'h55, 1'b0, 8'h00, 1'b1, 8'hC3};

        // ---------------- reset ----------------
        rst_n     = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 8'h00;
        bus_wdata = 8'h00;
        gpio_in   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rdata", int'(bus_rdata), 0);
        check("rst_ack", int'(bus_ack), 0);
        check("rst_err", int'(bus_err), 0);
        check("rst_gpio_out", int'(gpio_out), 0);
        check("rst_irq", int'(timer_irq), 0);
        check("rst_state", int'(dbg_state), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].chk_rd) exp_q.push_back(vecs[i].exp_rd);
            bus_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, ae);
            check($sformatf("v%0d_err", i), int'(er), int'(vecs[i].exp_err));
            check($sformatf("v%0d_gpio_out", i), int'(gpio_out), int'(vecs[i].exp_gpio));
            if (vecs[i].chk_rd) begin
                exp = exp_q.pop_front();
                check($sformatf("v%0d_rdata", i), int'(rd), int'(exp));
            end
        end

        // ---------------- timer / irq ----------------
        // TIMER_CMP is 0x10 from the table. Clear TIMER, read it back, then
        // clear any stale irq before the counted match.
        bus_xfer(1'b1, 8'hF2, 8'h00, rd, er, c_clr);
        bus_xfer(1'b0, 8'hF2, 8'h00, rd, er, ae);
        check("timer_read", int'(rd), (ae - c_clr - 1) & 8'hFF);
        bus_xfer(1'b1, 8'hF4, 8'h01, rd, er, ae);
        check("irq_cleared_early", int'(timer_irq), 0);
        irq_edge = -1;
        for (int i = 0; i < 40; i++) begin
            if (timer_irq) begin
                irq_edge = cyc;
                break;
            end
            @(negedge clk);
        end
        check("irq_rise_edge", irq_edge - c_clr, 17);
        bus_xfer(1'b0, 8'hF4, 8'h00, rd, er, ae);
        check("status_read_set", int'(rd), 1);
        bus_xfer(1'b1, 8'hF4, 8'h01, rd, er, ae);
        check("irq_clear", int'(timer_irq), 0);
        bus_xfer(1'b0, 8'hF4, 8'h00, rd, er, ae);
        check("status_read_clr", int'(rd), 0);

        // Clear on the same edge the match sets the flag: set must win.
        bus_xfer(1'b1, 8'hF2, 8'h00, rd, er, c_clr);
        while (cyc < c_clr + 13) @(negedge clk);
        check("irq_before_match", int'(timer_irq), 0);
        bus_xfer(1'b1, 8'hF4, 8'h01, rd, er, ae);
        check("clear_on_match_edge", ae - c_clr, 17);
        check("irq_set_wins", int'(timer_irq), 1);
        bus_xfer(1'b1, 8'hF4, 8'h01, rd, er, ae);
        check("irq_clear2", int'(timer_irq), 0);

        // ---------------- gpio_in ----------------
        gpio_in = 8'hA5;
        repeat (2) @(negedge clk);
        bus_xfer(1'b0, 8'hF1, 8'h00, rd, er, ae);
        check("gpio_in_read", int'(rd), 8'hA5);
        check("gpio_in_err", int'(er), 0);

        // ---------------- reset during WAIT ----------------
        bus_xfer(1'b1, 8'h01, 8'h22, rd, er, ae);
        bus_we    = 1'b1;
        bus_addr  = 8'h01;
        bus_wdata = 8'h99;
        bus_req   = 1'b1;
        @(negedge clk);
        check("mid_state_wait", int'(dbg_state), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", int'(bus_ack), 0);
        check("mid_rst_state", int'(dbg_state), 0);
        bus_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_gpio_out", int'(gpio_out), 0);
        bus_xfer(1'b0, 8'h01, 8'h00, rd, er, ae);
        check("mid_rst_ram_kept", int'(rd), 8'h22);
        bus_xfer(1'b0, 8'hF3, 8'h00, rd, er, ae);
        check("mid_rst_cmp", int'(rd), 0);

        // ---------------- req dropped before ack ----------------
        bus_we   = 1'b0;
        bus_addr = 8'h01;
        bus_req  = 1'b1;
        s        = cyc;
        @(negedge clk);
        bus_req  = 1'b0;
        ack_cnt  = 0;
        ae       = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_ack) begin
                ack_cnt++;
                if (ae < 0) begin
                    ae = cyc;
                    check("early_drop_rdata", int'(bus_rdata), 8'h22);
                end
            end
        end
        check("early_drop_ack_cycles", ack_cnt, 1);
        check("early_drop_ack_edge", ae - s, WS + 2);
        check("early_drop_idle", int'(dbg_state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
